// File: rtl/muldiv_if.sv
// muldiv_if: issue/result bundle between the EX stage and muldiv_unit.
//   start, op, src_a, src_b, flush : issue side, driven by EX (master)
//   busy, done, hi, lo             : status and HI/LO results, driven by the unit (slave)
interface muldiv_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src_a, src_b, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, flush,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit holding the architectural HI/LO
// registers. Executes MULT, MULTU, DIV, DIVU (WIDTH+1 cycle latency) and
// MTHI/MTLO (single edge).
//   clk  : processor clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : muldiv_if.slave -- start/op/src_a/src_b/flush in; busy/done/hi/lo out
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic [2*WIDTH-1:0]     acc;
  logic [WIDTH-1:0]       opnd;
  logic                   is_div;
  logic                   neg_q;
  logic                   neg_r;
  logic [WIDTH-1:0]       hi_r, lo_r;
  logic                   done_r;

  logic                   issue;
  logic                   sgn;
  logic [WIDTH-1:0]       mag_a, mag_b;
  logic [WIDTH:0]         mul_sum;
  logic [2*WIDTH-1:0]     mul_nxt;
  logic [WIDTH:0]         div_shift;
  logic [WIDTH:0]         div_trial;
  logic [2*WIDTH-1:0]     div_nxt;
  logic [2*WIDTH-1:0]     prod_fix;

  // Magnitude of an operand; the most-negative value maps to itself, which is
  // the correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v, input logic signed_op);
    logic signed [WIDTH-1:0] n;
    n = -v;
    return (signed_op && v < 0) ? WIDTH'(n) : WIDTH'(v);
  endfunction

  function automatic logic [WIDTH-1:0] fix_w(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] fix_2w(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

  assign issue = bus.start && !bus.flush && !bus.op[2];
  assign sgn   = !bus.op[0];
  assign mag_a = mag(bus.src_a, sgn);
  assign mag_b = mag(bus.src_b, sgn);

  // Multiply step: add multiplicand into the upper half when the current
  // multiplier bit (acc[0]) is set, then shift the whole accumulator right.
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_nxt = {mul_sum, acc[WIDTH-1:1]};

  // Restoring divide step: acc = {remainder, dividend/quotient}. Shift left,
  // trial-subtract the divisor, keep the difference only if non-negative.
  // A zero divisor always "succeeds", leaving remainder=|a| and quotient=all-ones.
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, opnd};
  assign div_nxt   = div_trial[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  assign prod_fix = fix_2w(acc, neg_q);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (issue) state_nxt = RUN;
      RUN: begin
        if (bus.flush)               state_nxt = IDLE;
        else if (cnt == CNT_W'(1))   state_nxt = FIN;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.busy = (state != IDLE);
    bus.done = done_r;
    bus.hi   = hi_r;
    bus.lo   = lo_r;
  end

  // Control and architectural registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (issue) begin
            cnt <= CNT_W'(WIDTH);
          end else if (bus.start && !bus.flush) begin
            if (bus.op == OP_MTHI) hi_r <= bus.src_a;
            if (bus.op == OP_MTLO) lo_r <= bus.src_a;
          end
        end
        RUN: begin
          if (bus.flush) cnt <= '0;
          else           cnt <= cnt - CNT_W'(1);
        end
        FIN: begin
          if (!bus.flush) begin
            done_r <= 1'b1;
            if (is_div) begin
              lo_r <= fix_w(acc[WIDTH-1:0], neg_q);
              hi_r <= fix_w(acc[2*WIDTH-1:WIDTH], neg_r);
            end else begin
              hi_r <= prod_fix[2*WIDTH-1:WIDTH];
              lo_r <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers: loaded at issue, stepped once per RUN edge
  always_ff @(posedge clk) begin
    if (state == IDLE && issue) begin
      is_div <= bus.op[1];
      if (bus.op[1]) begin
        acc   <= {{WIDTH{1'b0}}, mag_a};
        opnd  <= mag_b;
        // A zero divisor yields an all-ones quotient that is never negated.
        neg_q <= sgn && (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]) && (bus.src_b != '0);
        neg_r <= sgn && bus.src_a[WIDTH-1];
      end else begin
        acc   <= {{WIDTH{1'b0}}, mag_b};
        opnd  <= mag_a;
        neg_q <= sgn && (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
        neg_r <= 1'b0;
      end
    end else if (state == RUN) begin
      acc <= is_div ? div_nxt : mul_nxt;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  localparam int WIDTH = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_NOP   = 3'b110;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  muldiv_if #(.WIDTH(WIDTH)) bus ();

  muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op at the next rising edge; returns at the following negedge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.src_a = 32'hDEAD_BEEF;
    bus.src_b = 32'h0BAD_F00D;
    @(negedge clk);
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cyc;
    int done_in_busy;
    issue(op, a, b);
    cyc = 0;
    done_in_busy = 0;
    while (bus.busy === 1'b1 && cyc < 100) begin
      cyc++;
      if (bus.done !== 1'b0) done_in_busy++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 64'(cyc), 64'd33);
    check({tag, "_done_during_busy"}, 64'(done_in_busy), 64'd0);
    check({tag, "_done"}, 64'(bus.done), 64'd1);
    check({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
    @(negedge clk);
    check({tag, "_done_clear"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    int seen_done;
    n_assert = 0;
    n_fail   = 0;
    bus.start = 1'b0;
    bus.op    = OP_NOP;
    bus.src_a = '0;
    bus.src_b = '0;
    bus.flush = 1'b0;
    rst = 1'b0;

    repeat (2) @(negedge clk);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_hi",   64'(bus.hi),   64'd0);
    check("reset_lo",   64'(bus.lo),   64'd0);
    rst = 1'b1;
    @(negedge clk);

    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_neg",  OP_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("div_neg",   OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu",      OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14);
    run_op("divu_zero", OP_DIVU,  32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF);
    run_op("div_ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("div_zero_neg", OP_DIV, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF);

    // No-op code is ignored
    issue(OP_NOP, 32'h1357_9BDF, 32'd0);
    check("nop_busy", 64'(bus.busy), 64'd0);
    check("nop_hi",   64'(bus.hi),   64'hFFFF_FFF9);
    check("nop_lo",   64'(bus.lo),   64'hFFFF_FFFF);

    // Start while busy is ignored; flush aborts with no done
    issue(OP_DIV, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    issue(OP_MTHI, 32'h0000_00AA, 32'd0);
    check("busy_mthi_busy", 64'(bus.busy), 64'd1);
    check("busy_mthi_hi",   64'(bus.hi),   64'hFFFF_FFF9);
    repeat (4) @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_busy", 64'(bus.busy), 64'd0);
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen_done++;
      @(negedge clk);
    end
    check("flush_no_done", 64'(seen_done), 64'd0);
    check("flush_hi", 64'(bus.hi), 64'hFFFF_FFF9);
    check("flush_lo", 64'(bus.lo), 64'hFFFF_FFFF);

    // flush together with start in IDLE drops the MTLO
    bus.flush = 1'b1;
    issue(OP_MTLO, 32'h0000_0077, 32'd0);
    bus.flush = 1'b0;
    check("flush_start_lo", 64'(bus.lo), 64'hFFFF_FFFF);

    issue(OP_MTLO, 32'h0000_0055, 32'd0);
    check("mtlo_lo",   64'(bus.lo),   64'h55);
    check("mtlo_busy", 64'(bus.busy), 64'd0);
    check("mtlo_done", 64'(bus.done), 64'd0);

    // Asynchronous reset mid-RUN
    issue(OP_MTHI, 32'h0000_0011, 32'd0);
    issue(OP_MTLO, 32'h0000_0022, 32'd0);
    check("pre_hi", 64'(bus.hi), 64'h11);
    check("pre_lo", 64'(bus.lo), 64'h22);
    issue(OP_MULT, 32'd3, 32'd4);
    repeat (5) @(negedge clk);
    check("pre_rst_busy", 64'(bus.busy), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_busy", 64'(bus.busy), 64'd0);
    check("arst_done", 64'(bus.done), 64'd0);
    check("arst_hi",   64'(bus.hi),   64'd0);
    check("arst_lo",   64'(bus.lo),   64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_op("multu_after_rst", OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

- Iterative multiply/divide unit with architectural HI/LO registers for the pipelined processor. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- It sits beside the EX-stage ALU. The hazard unit holds IF/ID/EX while `busy` is high, so MFHI/MFLO and the next mul/div never observe a stale value.
- Operand width is parametrised. Latency is a fixed WIDTH+1 cycles.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width; legal range 4..64.
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- clk  input  1  processor clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  issue strobe from EX; sampled only when `busy`=0.
- op  input  3  operation code:
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO.
  - 110/111 are no-ops.
- src_a  input  WIDTH  multiplicand, dividend, or MTHI/MTLO data.
- src_b  input  WIDTH  multiplier or divisor.
- flush  input  1  abort any in-flight op.
- busy  output  1  op in flight; hazard unit stalls on it.
- done  output  1  one-cycle pulse in the cycle HI/LO show a new mul/div result.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

## Operation
- States: IDLE, RUN, FIN.
- Reset (rst=0, asynchronous, immediate): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. Reset asserted mid-operation discards the op.
- IDLE, start=1, flush=0:
  - MULT/MULTU/DIV/DIVU: latch operand magnitudes and result-sign flags, load counter=WIDTH, go to RUN.
  - MTHI/MTLO: write src_a to hi/lo at this edge; stay in IDLE; no busy, no done.
  - op 110/111: ignored.
- RUN: one iteration per edge, counter decrements. At counter 1→0, go to FIN.
  - Multiply: shift-add on a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract producing quotient and remainder.
- FIN: apply sign fix-up, write hi/lo, pulse done, go to IDLE.
- Arithmetic rules:
  - Mult result: HI = product[2W-1:W], LO = product[W-1:0].
  - Signed mult: operate on |a|·|b|; negate the 2W product if signs differ.
  - Div result: LO = quotient, HI = remainder.
  - Signed div: quotient is negative if signs differ. Remainder takes the sign of the dividend (truncating division).
  - Divide by zero (DIV or DIVU): HI = src_a, LO = all-ones. Latency is normal.
  - Signed overflow (most-negative / −1): LO = most-negative, HI = 0. This falls out of the magnitude method; no special case is needed.
- Operands are latched at start. src_a/src_b may change during RUN without effect.
- start while busy=1 is ignored. EX must hold the instruction under stall and not re-issue it.
- flush=1 in RUN or FIN: go to IDLE at next edge; hi/lo unchanged; no done.
- flush=1 with start=1 in IDLE: start ignored, including MTHI/MTLO.

## Timing
- Issue at edge E0: busy=1 from E0 through E0+WIDTH+1.
- Edges E0+1..E0+WIDTH perform the WIDTH iterations.
- At edge E0+WIDTH+1: hi/lo updated, done=1, busy=0 for the following cycle.
- Total latency: WIDTH+1 cycles from issue edge to result visible (33 for WIDTH=32).
- Back-to-back: a new start may be sampled in the done cycle; minimum repeat interval is WIDTH+2 cycles.
- MTHI/MTLO latency: 1 edge; value visible in the cycle after issue.
- done is never asserted in the same cycle as busy.
- hi/lo are registered outputs with no combinational path from any input.

## Test plan
- Reset, then MULTU with 0xFFFFFFFF × 0xFFFFFFFF (WIDTH=32):
  - busy is high for exactly 33 cycles.
  - done pulses once; HI=0xFFFFFFFE, LO=0x00000001.
- MULT −3 × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- Divides:
  - DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 100 / 7 → LO=14, HI=2.
- Divide edge cases:
  - DIVU 0x1234 / 0 → HI=0x1234, LO=0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
  - Both complete in 33 cycles.
- Start DIV, then:
  - Pulse start with MTHI 0xAA at RUN cycle 5 → ignored.
  - Assert flush at RUN cycle 10 → busy low next cycle, no done, hi/lo keep prior values.
  - Then MTLO 0x55 in IDLE → lo=0x55 one edge later.
- Preload hi/lo = 0x11/0x22 via MTHI/MTLO. Start MULT, pull rst low asynchronously mid-RUN (between edges):
  - busy, done, hi, lo go to 0 immediately without a clock edge.
  - After release, a new MULTU 6 × 7 gives LO=42, HI=0.
